data_memory: RTL
================

# data_memory

Line-granular backing memory that serves the data cache controller's miss traffic: 256-bit (32-byte) line reads for allocation and line writes for dirty write-back. Each accepted request completes after a fixed, parameterised latency and is answered with a single-cycle acknowledge. It sits directly below the cache controller, on its memory-side port, and models main memory for simulation and synthesis.

## Interface
- LATENCY, 10: cycles from request acceptance to the ack_o cycle; legal range 1..255.
- DEPTH, 512: number of 256-bit lines; power of two; index width IDX = log2(DEPTH).
- clock_i  input  1  single clock; all state updates on its rising edge.
- flush_i  input  1  reset, synchronous, active-high.
- enable_i  input  1  request valid; held by the requester until it sees ack_o.
- write_i  input  1  1 = line write, 0 = line read; sampled with enable_i.
- addr_i  input  32  byte address; line index = addr_i[IDX+4:5].
- data_i  input  256  write line; sampled with enable_i.
- ack_o  output  1  one-cycle completion pulse.
- data_o  output  256  read line; valid from the ack_o cycle and held.

## Operation
- Storage: DEPTH x 256-bit array. Not cleared by flush_i; contents are preserved across reset.
- Address handling:
  - addr_i[4:0] is ignored.
  - addr_i[31:IDX+5] is ignored, so addresses wrap modulo DEPTH lines.
- State machine: IDLE, WAIT, ACK.
- IDLE:
  - If enable_i=1, latch write_i, the line index, and data_i (writes only).
  - Load the counter with LATENCY-1 and go to WAIT. If LATENCY=1, go straight to the completion edge (see WAIT).
  - If enable_i=0, stay in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - Inputs are ignored. Deassertion of enable_i does not abort the request, and changes to addr_i, write_i and data_i have no effect.
  - On the edge where the counter is 0 (the completion edge):
    - Write: commit the latched line to the array.
    - Read: load data_o with array[index].
    - Set ack_o=1 and go to ACK.
- ACK:
  - ack_o=1 for this cycle only.
  - On the next edge, clear ack_o and go to IDLE.
  - enable_i is not sampled in ACK. A requester that keeps enable_i high for a follow-on request, such as write-back followed by allocate, is accepted in the next IDLE cycle.
- Write completion leaves data_o unchanged.
- A read of a line written earlier returns the written value. This includes a read accepted in the IDLE cycle directly after that write's ACK.
- Counter width: 8 bits.

## Timing
- Reset (flush_i=1 at an edge):
  - state=IDLE, counter=0, ack_o=0, data_o=256'b0.
  - Latched address, write flag and write data are cleared to 0.
  - Reset takes priority over every other event.
- Reset mid-operation: a request in WAIT is dropped. No array write and no ack_o occur, even if the reset edge coincides with the completion edge.
- Latency: with a request accepted at edge E0, the completion edge is E0+LATENCY. ack_o is high from E0+LATENCY to E0+LATENCY+1.
- Throughput: at most one request per LATENCY+2 cycles (accept, wait, ack, idle).
- data_o is registered. It changes only at a read completion edge or at reset.
- ack_o is registered, with no combinational path from any input.

## Test plan
- Reset values: assert flush_i for 2 cycles with enable_i=1 -> ack_o=0 and data_o=0 throughout. The first ack_o occurs exactly LATENCY cycles after the first post-reset acceptance edge.
- Write then read (LATENCY=10):
  - Write addr 0x0000_0040, data {8{32'hDEADBEEF}} -> ack_o high exactly at edge E0+10, for 1 cycle, with data_o unchanged.
  - Read addr 0x0000_0040 -> data_o={8{32'hDEADBEEF}} in its ack cycle.
- Back-to-back, enable_i held high across ACK:
  - Write line 3 = 256'h1, then with enable_i still high switch to read line 3 -> second acceptance occurs in the IDLE cycle after ACK and returns 256'h1.
  - Exactly 2 ack_o pulses, 12 cycles apart.
- Address aliasing (DEPTH=512):
  - Write addr 0x0000_0020 with 256'hA5.
  - Read addr 0x0000_403F (same index 1, different offset bits and upper bits) -> data_o=256'hA5.
- Reset mid-write:
  - Write line 5 = 256'hFF; pulse flush_i at acceptance+5 -> no ack_o.
  - A later read of line 5 returns its prior contents, not 256'hFF.
- Input changes during WAIT:
  - Read line 2 (holding 256'h22); at acceptance+2 drop enable_i and change addr_i to line 7 (holding 256'h77) -> ack_o still fires at +LATENCY with data_o=256'h22.
  - With LATENCY=1, ack_o fires 1 cycle after acceptance.

Source files
------------

// File: rtl/data_memory.sv
// Line-granular backing memory below the data cache: 256-bit line reads and
// write-backs, each completing after a fixed LATENCY with a one-cycle ack.
module data_memory #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512
) (
  input  logic         clock_i,
  input  logic         flush_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o
);
  localparam int IDX = $clog2(DEPTH);
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t         state;
  logic [7:0]     cnt;
  logic [IDX-1:0] idx_p0;
  logic           wr_p0;
  logic [255:0]   wdata_p0;
  logic [255:0]   mem [DEPTH];
  logic           done;
  logic           unused_addr;

  // Offset bits and bits above the index alias onto the same line.
  assign unused_addr = ^{addr_i[4:0], addr_i[31:IDX+5]};
  assign done        = (state == WAIT) && (cnt == 8'd0);

  // Array commit; a reset edge that lands on the completion edge drops the write.
  always_ff @(posedge clock_i) begin
    if (!flush_i && done && wr_p0) begin
      mem[idx_p0] <= wdata_p0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (flush_i) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      ack_o    <= 1'b0;
      data_o   <= '0;
      idx_p0   <= '0;
      wr_p0    <= 1'b0;
      wdata_p0 <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_o <= 1'b0;
          if (enable_i) begin
            wr_p0  <= write_i;
            idx_p0 <= addr_i[IDX+4:5];
            if (write_i) begin
              wdata_p0 <= data_i;
            end
            cnt   <= CNT_LOAD;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            if (!wr_p0) begin
              data_o <= mem[idx_p0];
            end
            ack_o <= 1'b1;
            state <= ACK;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACK: begin
          ack_o <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
